// File: rtl/sdram_bridge_pkg.sv
// Shared types and constants for the CPU-bus to DDR3 application-interface bridge.
package sdram_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b000;

endpackage

// File: rtl/sdram_line_cache.sv
// Single-line read cache: tag/valid/data, hit detection, fill on read return,
// byte merge on write-through to the cached line.
module sdram_line_cache #(
  parameter int unsigned APP_DATA_WIDTH = 128
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [31:0]                 i_lookup_addr,
  output logic                        o_hit,
  output logic [APP_DATA_WIDTH-1:0]   o_line,
  input  logic                        i_fill,
  input  logic [31:0]                 i_fill_addr,
  input  logic [APP_DATA_WIDTH-1:0]   i_fill_data,
  input  logic                        i_merge,
  input  logic [APP_DATA_WIDTH-1:0]   i_merge_data,
  input  logic [APP_DATA_WIDTH/8-1:0] i_merge_be
);

  localparam int unsigned LS = $clog2(APP_DATA_WIDTH / 8);
  localparam int unsigned NB = APP_DATA_WIDTH / 8;

  logic                      valid_q;
  logic [31-LS:0]            tag_q;
  logic [APP_DATA_WIDTH-1:0] line_q;

  // Offset bits within the line never take part in the tag.
  logic unused_offset;
  assign unused_offset = ^{i_lookup_addr[LS-1:0], i_fill_addr[LS-1:0]};

  assign o_hit  = valid_q && (tag_q == i_lookup_addr[31:LS]);
  assign o_line = line_q;

  // Fill replaces the whole line; a write hitting the line merges only enabled bytes.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      line_q  <= '0;
    end else if (i_fill) begin
      valid_q <= 1'b1;
      tag_q   <= i_fill_addr[31:LS];
      line_q  <= i_fill_data;
    end else if (i_merge && o_hit) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (i_merge_be[b]) line_q[b*8 +: 8] <= i_merge_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/sdram_app_bridge.sv
// CPU memory bus to DDR3 native app interface bridge: lane select, partial-write
// masks, read-lane extraction, independent cmd/wdf back-pressure.
// Optional one-line read cache enabled by defining SDRAM_LINE_CACHE_EN.
module sdram_app_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_ADDR_WIDTH = 28
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_request,
  input  logic                        i_rw,
  input  logic [31:0]                 i_address,
  input  logic [DATA_WIDTH-1:0]       i_wdata,
  input  logic [DATA_WIDTH/8-1:0]     i_wmask,
  output logic [DATA_WIDTH-1:0]       o_rdata,
  output logic                        o_ready,
  input  logic                        i_calib_complete,
  output logic [APP_ADDR_WIDTH-1:0]   o_app_addr,
  output logic [2:0]                  o_app_cmd,
  output logic                        o_app_en,
  input  logic                        i_app_rdy,
  output logic [APP_DATA_WIDTH-1:0]   o_app_wdf_data,
  output logic [APP_DATA_WIDTH/8-1:0] o_app_wdf_mask,
  output logic                        o_app_wdf_wren,
  output logic                        o_app_wdf_end,
  input  logic                        i_app_wdf_rdy,
  input  logic [APP_DATA_WIDTH-1:0]   i_app_rd_data,
  input  logic                        i_app_rd_data_valid
);

  localparam int unsigned LS    = $clog2(APP_DATA_WIDTH / 8);
  localparam int unsigned WS    = $clog2(DATA_WIDTH / 8);
  localparam int unsigned LANES = APP_DATA_WIDTH / DATA_WIDTH;
  localparam int unsigned DB    = DATA_WIDTH / 8;

  state_t                      state;
  logic                        ready_q;
  logic [31:0]                 held_addr;
  int unsigned                 req_lane;
  int unsigned                 held_lane;
  logic [APP_DATA_WIDTH-1:0]   wdf_line;
  logic [APP_DATA_WIDTH/8-1:0] wdf_mask;
  logic [APP_DATA_WIDTH/8-1:0] merge_be;
  logic [DATA_WIDTH-1:0]       hit_lane;
  logic [DATA_WIDTH-1:0]       rd_lane;
  logic [APP_ADDR_WIDTH-1:0]   line_addr;
  logic                        en_left;
  logic                        wren_left;
  logic                        start;
  logic                        cache_hit;
  logic [APP_DATA_WIDTH-1:0]   cache_line;

  logic unused_bits;
  assign unused_bits = ^{i_address, held_addr, i_app_rd_data, merge_be};

  assign req_lane  = 32'(i_address[LS-1:0]) >> WS;
  assign held_lane = 32'(held_addr[LS-1:0]) >> WS;
  assign line_addr = {i_address[APP_ADDR_WIDTH-1:LS], {LS{1'b0}}};
  assign en_left   = o_app_en && !i_app_rdy;
  assign wren_left = o_app_wdf_wren && !i_app_wdf_rdy;
  assign start     = (state == ST_IDLE) && i_request && i_calib_complete;

  assign o_ready       = ready_q && i_request;
  assign o_app_wdf_end = o_app_wdf_wren;

  // Place write data/mask into the addressed lane and pick lanes out of returned lines.
  always_comb begin
    wdf_line = '0;
    wdf_mask = '1;
    merge_be = '0;
    hit_lane = '0;
    rd_lane  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (l == req_lane) begin
        wdf_line[l*DATA_WIDTH +: DATA_WIDTH] = i_wdata;
        wdf_mask[l*DB +: DB]                 = ~i_wmask;
        merge_be[l*DB +: DB]                 = i_wmask;
        hit_lane                             = cache_line[l*DATA_WIDTH +: DATA_WIDTH];
      end
      if (l == held_lane) rd_lane = i_app_rd_data[l*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef SDRAM_LINE_CACHE_EN
  sdram_line_cache #(.APP_DATA_WIDTH(APP_DATA_WIDTH)) u_line_cache (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_lookup_addr (i_address),
    .o_hit         (cache_hit),
    .o_line        (cache_line),
    .i_fill        ((state == ST_READ) && i_app_rd_data_valid),
    .i_fill_addr   (held_addr),
    .i_fill_data   (i_app_rd_data),
    .i_merge       (start && i_rw),
    .i_merge_data  (wdf_line),
    .i_merge_be    (merge_be)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_line = '0;
`endif

  // Transaction FSM with registered app-side outputs and CPU handshake.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state          <= ST_IDLE;
      ready_q        <= 1'b0;
      held_addr      <= '0;
      o_rdata        <= '0;
      o_app_addr     <= '0;
      o_app_cmd      <= '0;
      o_app_en       <= 1'b0;
      o_app_wdf_wren <= 1'b0;
      o_app_wdf_data <= '0;
      o_app_wdf_mask <= '1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            held_addr <= i_address;
            if (i_rw) begin
              o_app_addr     <= line_addr;
              o_app_cmd      <= CMD_WRITE;
              o_app_en       <= 1'b1;
              o_app_wdf_wren <= 1'b1;
              o_app_wdf_data <= wdf_line;
              o_app_wdf_mask <= wdf_mask;
              state          <= ST_WRITE;
            end else if (cache_hit) begin
              o_rdata <= hit_lane;
              state   <= ST_DONE;
            end else begin
              o_app_addr <= line_addr;
              o_app_cmd  <= CMD_READ;
              o_app_en   <= 1'b1;
              state      <= ST_READ;
            end
          end
        end
        ST_READ: begin
          o_app_en <= en_left;
          if (i_app_rd_data_valid) begin
            o_rdata  <= rd_lane;
            o_app_en <= 1'b0;
            ready_q  <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_WRITE: begin
          o_app_en       <= en_left;
          o_app_wdf_wren <= wren_left;
          if (!en_left && !wren_left) begin
            ready_q <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          // A hit arrives here with ready_q low and raises it one cycle later.
          if (!i_request) begin
            ready_q <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            ready_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
